// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the synchronous imem and hands
// instructions to the decoder over valid/ready. Optional bex redirect: FETCH_BEX_EN.
module fetch_unit #(
  parameter int PC_W = 12
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] address_imem,
  input  logic [31:0]     q_imem,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     pc_plus1,
  input  logic            select_j,
  input  logic            select_jal,
  input  logic            select_jr,
  input  logic            select_branch,
  input  logic            is_bex,
  input  logic            branch_cond,
  input  logic            rstatus_nonzero,
  input  logic [26:0]     target,
  input  logic [31:0]     immediate_num,
  input  logic [31:0]     data_readRegB,
  output logic [31:0]     retired
);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     retired_q, retired_d;

  logic            accept;
  logic            bex_take;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] branch_pc;
  logic [PC_W-1:0] next_pc;

  // jal shares the j target path; its link value comes from pc_plus1.
  logic unused_inputs;
  assign unused_inputs = ^{select_jal, target[26:PC_W], immediate_num[31:PC_W],
                           data_readRegB[31:PC_W]};

`ifdef FETCH_BEX_EN
  assign bex_take = is_bex & rstatus_nonzero;
`else
  logic unused_bex;
  assign unused_bex = is_bex ^ rstatus_nonzero;
  assign bex_take   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    instr_valid = 1'b0;
    case (state_q)
      PRIME:   instr_valid = 1'b0;
      RUN:     instr_valid = 1'b1;
      default: instr_valid = 1'b0;
    endcase
  end

  assign accept = instr_valid & instr_ready;

  assign pc_inc    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign branch_pc = pc_inc + immediate_num[PC_W-1:0];

  // Redirect priority: jr, taken bex, j/jal, taken branch, sequential.
  always_comb begin
    next_pc = pc_inc;
    if (select_jr) begin
      next_pc = data_readRegB[PC_W-1:0];
    end else if (bex_take) begin
      next_pc = target[PC_W-1:0];
    end else if (select_j) begin
      next_pc = target[PC_W-1:0];
    end else if (select_branch && branch_cond) begin
      next_pc = branch_pc;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    if (accept) begin
      pc_d      = next_pc;
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // The ROM is addressed with the post-edge PC so redirects cost no bubble.
  assign address_imem = pc_d;
  assign instr        = q_imem;
  assign pc           = pc_q;
  assign pc_plus1     = {{(32-PC_W){1'b0}}, pc_inc};
  assign retired      = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural PC model plus directed vectors.
// Bex expectations follow FETCH_BEX_EN as seen by the bench.
module tb_fetch_unit;

  localparam int PC_W = 12;

  logic            clock;
  logic            reset;
  logic [PC_W-1:0] address_imem;
  logic [31:0]     q_imem;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [31:0]     pc_plus1;
  logic            select_j, select_jal, select_jr, select_branch, is_bex;
  logic            branch_cond, rstatus_nonzero;
  logic [26:0]     target;
  logic [31:0]     immediate_num;
  logic [31:0]     data_readRegB;
  logic [31:0]     retired;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] rom [4096];

  int  m_pc;
  bit  m_run;
  int unsigned m_retired;

  fetch_unit #(.PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus1(pc_plus1), .select_j(select_j), .select_jal(select_jal),
    .select_jr(select_jr), .select_branch(select_branch), .is_bex(is_bex),
    .branch_cond(branch_cond), .rstatus_nonzero(rstatus_nonzero), .target(target),
    .immediate_num(immediate_num), .data_readRegB(data_readRegB), .retired(retired)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
  end

  always @(posedge clock) q_imem <= rom[address_imem];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Where the PC must go if the current instruction retires, in plain integer math.
  function automatic int model_next();
    bit bex_on;
`ifdef FETCH_BEX_EN
    bex_on = 1'b1;
`else
    bex_on = 1'b0;
`endif
    if (select_jr) return int'(data_readRegB) & 4095;
    if (bex_on && is_bex && rstatus_nonzero) return int'(target) % 4096;
    if (select_j) return int'(target) % 4096;
    if (select_branch && branch_cond) return (m_pc + 1 + int'(immediate_num)) & 4095;
    return (m_pc + 1) % 4096;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc      = 0;
      m_run     = 1'b0;
      m_retired = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (instr_ready) begin
      m_pc      = model_next();
      m_retired = m_retired + 1;
    end
  end

  always @(negedge clock) begin
    checkOutput("m_valid", {31'b0, instr_valid}, {31'b0, m_run});
    checkOutput("m_pc", {20'b0, pc}, m_pc);
    checkOutput("m_pc_plus1", pc_plus1, (m_pc + 1) % 4096);
    checkOutput("m_retired", retired, m_retired);
    checkOutput("m_addr", {20'b0, address_imem},
                !m_run ? 0 : (instr_ready ? model_next() : m_pc));
    if (m_run) checkOutput("m_instr", instr, rom[m_pc]);
  end

  task automatic clear_ctrl();
    select_j = 0; select_jal = 0; select_jr = 0; select_branch = 0; is_bex = 0;
    branch_cond = 0; rstatus_nonzero = 0; target = '0; immediate_num = '0;
    data_readRegB = '0;
  endtask

  // Advance one clock, landing just after the edge where inputs may change.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    reset = 1'b1;
    instr_ready = 1'b0;
    clear_ctrl();
    applyStimulus(1);
    checkOutput("rst_pc", {20'b0, pc}, 0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_addr", {20'b0, address_imem}, 0);

    reset = 1'b0;
    instr_ready = 1'b1;
    #1;
    checkOutput("prime_valid", {31'b0, instr_valid}, 0);
    checkOutput("prime_addr", {20'b0, address_imem}, 0);
    applyStimulus(1);
    checkOutput("first_valid", {31'b0, instr_valid}, 1);
    checkOutput("first_pc", {20'b0, pc}, 0);
    checkOutput("first_instr", instr, 32'hA5A5_0000);
    applyStimulus(3);
    checkOutput("seq_pc3", {20'b0, pc}, 3);
    checkOutput("seq_retired3", retired, 3);

    applyStimulus(2);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("stall_pc", {20'b0, pc}, 5);
      checkOutput("stall_instr", instr, rom[5]);
      checkOutput("stall_retired", retired, 5);
    end
    instr_ready = 1'b1;
    applyStimulus(5);
    checkOutput("pre_jal_pc", {20'b0, pc}, 10);

    select_j = 1; select_jal = 1; target = 27'd200;
    #1;
    checkOutput("jal_plus1", pc_plus1, 11);
    checkOutput("jal_addr", {20'b0, address_imem}, 200);
    applyStimulus(1);
    clear_ctrl();
    checkOutput("jal_pc", {20'b0, pc}, 200);
    checkOutput("jal_instr", instr, rom[200]);

    select_j = 1; target = 27'd20;
    applyStimulus(1);
    clear_ctrl();
    checkOutput("j_pc", {20'b0, pc}, 20);
    select_branch = 1; branch_cond = 1; immediate_num = 32'hFFFF_FFFB;
    applyStimulus(1);
    clear_ctrl();
    checkOutput("br_taken_pc", {20'b0, pc}, 16);
    select_j = 1; target = 27'd20;
    applyStimulus(1);
    clear_ctrl();
    select_branch = 1; branch_cond = 0; immediate_num = 32'hFFFF_FFFB;
    applyStimulus(1);
    clear_ctrl();
    checkOutput("br_not_taken_pc", {20'b0, pc}, 21);

    select_j = 1; target = 27'd30;
    applyStimulus(1);
    clear_ctrl();
    select_jr = 1; data_readRegB = 32'h0000_1064;
    applyStimulus(1);
    clear_ctrl();
    checkOutput("jr_pc", {20'b0, pc}, 32'h64);
    select_jr = 1; data_readRegB = 32'd30; select_j = 1; target = 27'd500;
    applyStimulus(1);
    clear_ctrl();
    checkOutput("jr_over_j_pc", {20'b0, pc}, 30);

    instr_ready = 1'b0; select_j = 1; target = 27'd700;
    #1;
    checkOutput("noacc_addr", {20'b0, address_imem}, 30);
    applyStimulus(1);
    checkOutput("noacc_pc", {20'b0, pc}, 30);
    instr_ready = 1'b1;
    clear_ctrl();

    select_j = 1; target = 27'd4094;
    applyStimulus(1);
    clear_ctrl();
    applyStimulus(1);
    checkOutput("top_pc", {20'b0, pc}, 4095);
    checkOutput("top_plus1", pc_plus1, 0);
    applyStimulus(1);
    checkOutput("wrap_pc", {20'b0, pc}, 0);
    select_branch = 1; branch_cond = 1; immediate_num = 32'hFFFF_FFFE;
    applyStimulus(1);
    clear_ctrl();
    checkOutput("br_wrap_pc", {20'b0, pc}, 4095);

    is_bex = 1; rstatus_nonzero = 1; target = 27'd300;
    applyStimulus(1);
    clear_ctrl();
`ifdef FETCH_BEX_EN
    checkOutput("bex_pc", {20'b0, pc}, 300);
`else
    checkOutput("bex_pc", {20'b0, pc}, 0);
`endif
    is_bex = 1; rstatus_nonzero = 0; target = 27'd900;
    applyStimulus(1);
    clear_ctrl();
    applyStimulus(3);

    reset = 1'b1;
    #1;
    checkOutput("midrst_pc", {20'b0, pc}, 0);
    checkOutput("midrst_valid", {31'b0, instr_valid}, 0);
    checkOutput("midrst_retired", retired, 0);
    applyStimulus(1);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_valid", {31'b0, instr_valid}, 1);
    checkOutput("post_rst_pc", {20'b0, pc}, 0);
    applyStimulus(3);
    checkOutput("post_rst_retired", retired, 3);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle processor. It owns the 12-bit program counter, drives the synchronous instruction ROM address, and presents the fetched word to the instruction decoder under a valid/ready handshake. It takes the decoder's PC-control outputs (jump, jump-and-link, jump-register, branch, bex) and computes the next PC. It also supplies PC+1 for the jal write-back and keeps a retired-instruction counter for debug.

## Interface
- PC_W, 12: PC and ROM address width (4096-word imem).
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high reset.
- address_imem  out  PC_W  ROM address. Combinational: equals the PC value that will hold after the coming edge.
- q_imem  in  32  ROM read data. Data for the address sampled at the previous edge.
- instr  out  32  instruction to the decoder; passthrough of q_imem.
- instr_valid  out  1  instr is a real instruction for the current PC.
- instr_ready  in  1  decoder/datapath can retire instr this cycle.
- pc  out  PC_W  address of instr.
- pc_plus1  out  32  zero-extended pc+1 (mod 2^PC_W), jal write-back data.
- select_j, select_jal, select_jr, select_branch, is_bex  in  1 each  decoder PC controls.
- branch_cond  in  1  ALU branch condition (ne / lt) true.
- rstatus_nonzero  in  1  $r30 != 0.
- target  in  27  T field, q_imem[26:0].
- immediate_num  in  32  sign-extended N.
- data_readRegB  in  32  $rd value for jr.
- retired  out  32  count of accepted instructions.

## Operation
- States: PRIME, RUN.
  - Reset forces PRIME, pc=0, retired=0, and address_imem=0.
  - PRIME lasts exactly one cycle with instr_valid=0 and address_imem=0 while the ROM loads word 0. It then goes to RUN.
  - RUN has no exit except reset.
- instr_valid=1 in RUN, 0 in PRIME.
- accept = instr_valid & instr_ready.
- Without accept, pc holds and address_imem=pc, so q_imem and instr stay stable.
- On accept, next_pc is chosen by the first matching condition in this priority order:
  - select_jr: data_readRegB[PC_W-1:0].
  - is_bex & rstatus_nonzero: target[PC_W-1:0]. See Configuration.
  - select_j (with or without select_jal): target[PC_W-1:0].
  - select_branch & branch_cond: pc+1+immediate_num[PC_W-1:0].
  - otherwise: pc+1.
- All PC arithmetic is mod 2^PC_W. 4095+1 wraps to 0; 0+1+(-2) gives 4095.
- Redirect and PC-control inputs are ignored when there is no accept.
- retired increments by 1 on each accept and wraps from 2^32-1 to 0.
- Reset mid-run: PC, state and retired clear immediately (asynchronous). No partial instruction is reported.

## Timing
- ROM read latency is 1 cycle. Because address_imem carries next_pc in the same cycle, the target instruction is valid in the cycle right after any accept. There is no redirect bubble.
- Throughput is 1 instruction per cycle while instr_ready=1.
- The first valid instruction (word 0) appears 1 cycle after reset deasserts.
- The path from target, immediate_num, data_readRegB and branch_cond to address_imem is combinational. It is the critical path.
- pc_plus1 is combinational from pc.

## Configuration
- FETCH_BEX_EN defined: bex redirects as described in Operation.
- FETCH_BEX_EN undefined: is_bex and rstatus_nonzero are ignored, and a bex instruction falls through to pc+1. The ports stay present.

## Test plan
- Reset then instr_ready=1 with no controls: instr_valid rises 1 cycle after reset, pc steps 0,1,2,3, and retired=3 after 3 accepts.
- At pc=5, hold instr_ready=0 for 3 cycles: pc stays 5, instr equals ROM[5] throughout, and retired is unchanged.
- At pc=10, select_j=1 with target=27'd200: the next cycle has pc=200 and instr=ROM[200]. Repeat with select_jal=1: pc_plus1=11 during the jal cycle.
- At pc=20, select_branch=1 with immediate_num=-5: branch_cond=1 gives pc=16; branch_cond=0 gives pc=21.
- At pc=30, select_jr=1 with data_readRegB=32'h0000_1064: pc=0x064. Also apply select_jr and select_j together: jr wins.
- At pc=4095 with sequential flow: pc=0. Check is_bex with rstatus_nonzero=1 and target=300: pc=300 with FETCH_BEX_EN, pc=4096 mod 4096=0 without it. Apply reset mid-stream: pc=0, retired=0, instr_valid=0 immediately.
